// File: rtl/imem_dmem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Used by imem_dmem_arbiter and arb_pick2.
package imem_dmem_arb_pkg;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Owner of the transaction currently in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

endpackage

// File: rtl/imem_dmem_arbiter_pick2.sv
// arb_pick2: two-way tie-break for the fetch and load/store requesters.
// If ARB_ROUND_ROBIN_EN is defined, a tie goes to the requester that did not
// win last time, and last_grant is updated on every accepted request.
// Otherwise data always beats fetch, and no state is kept.
module arb_pick2
  import imem_dmem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       reset_n,
  input  logic       update,
`endif
  input  logic       valid_i,
  input  logic       valid_d,
  output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant;

  // Pick the winner. A tie goes to the requester that did not win last time.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant = '0;
    if (valid_i && valid_d) begin
      if (last_grant == OWN_D) grant[GNT_I] = 1'b1;
      else                     grant[GNT_D] = 1'b1;
    end else if (valid_i) begin
      grant[GNT_I] = 1'b1;
    end else if (valid_d) begin
      grant[GNT_D] = 1'b1;
    end
  end

  // Remember who won the last accepted request. Reset to DATA so the first tie goes to fetch.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_grant <= OWN_D;
    else if (update) last_grant <= grant[GNT_D] ? OWN_D : OWN_I;
  end
`else
  // Fixed priority: data wins any tie.
  always_comb begin
    grant = '0;
    if (valid_d)      grant[GNT_D] = 1'b1;
    else if (valid_i) grant[GNT_I] = 1'b1;
  end
`endif

endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one memory request/response port between the
// instruction fetch and the load/store requesters. Only one transaction is
// in flight at a time (IDLE -> REQ -> RESP). The ARB_ROUND_ROBIN_EN define
// selects round-robin tie-breaking; without it, data has fixed priority.
module imem_dmem_arbiter
  import imem_dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  // fetch requester
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_valid,
  input  logic                i_resp_ready,
  output logic [DATA_W-1:0]   i_resp_data,
  // load/store requester
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_resp_valid,
  input  logic                d_resp_ready,
  output logic [DATA_W-1:0]   d_resp_data,
  // memory port
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_we,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  input  logic                m_resp_valid,
  output logic                m_resp_ready,
  input  logic [DATA_W-1:0]   m_resp_data,
  output logic                busy
);

  arb_state_e state;
  owner_e     owner;
  logic [1:0] grant;
  logic       in_idle;
  logic       i_fire;
  logic       d_fire;
  logic       resp_fire;

  assign in_idle = (state == IDLE);

  arb_pick2 u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk     (clk),
    .reset_n (reset_n),
    .update  (i_fire | d_fire),
`endif
    .valid_i (i_req_valid),
    .valid_d (d_req_valid),
    .grant   (grant)
  );

  // Ready goes only to the winner, only in IDLE, in the same cycle as its valid.
  assign i_req_ready = in_idle & grant[GNT_I];
  assign d_req_ready = in_idle & grant[GNT_D];
  assign i_fire      = i_req_valid & i_req_ready;
  assign d_fire      = d_req_valid & d_req_ready;

  // The response path goes straight from memory to the owner. The non-owner never sees valid.
  assign m_resp_ready = (state == RESP) &
                        ((owner == OWN_I) ? i_resp_ready : d_resp_ready);
  assign i_resp_valid = (state == RESP) & (owner == OWN_I) & m_resp_valid;
  assign d_resp_valid = (state == RESP) & (owner == OWN_D) & m_resp_valid;
  assign i_resp_data  = m_resp_data;
  assign d_resp_data  = m_resp_data;
  assign resp_fire    = m_resp_valid & m_resp_ready;

  // Transaction FSM: capture the winner, hold it to memory, wait for the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= OWN_I;
      m_req_valid <= 1'b0;
      busy        <= 1'b0;
      m_req_addr  <= '0;
      m_req_we    <= 1'b0;
      m_req_wdata <= '0;
      m_req_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_fire) begin
            owner       <= OWN_D;
            m_req_addr  <= d_req_addr;
            m_req_we    <= d_req_we;
            m_req_wdata <= d_req_wdata;
            m_req_wstrb <= d_req_wstrb;
            m_req_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= REQ;
          end else if (i_fire) begin
            owner       <= OWN_I;
            m_req_addr  <= i_req_addr;
            m_req_we    <= 1'b0;
            m_req_wdata <= '0;
            m_req_wstrb <= '0;
            m_req_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (m_req_ready) begin
            m_req_valid <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (resp_fire) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          m_req_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed testbench for imem_dmem_arbiter. Expected grant order depends on
// whether ARB_ROUND_ROBIN_EN is defined for the build.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid, i_resp_ready;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_resp_valid, d_resp_ready;
  logic [31:0] d_resp_data;
  logic        m_req_valid, m_req_ready;
  logic [31:0] m_req_addr;
  logic        m_req_we;
  logic [31:0] m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_resp_valid, m_resp_ready;
  logic [31:0] m_resp_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_req_addr   (i_req_addr),
    .i_resp_valid (i_resp_valid),
    .i_resp_ready (i_resp_ready),
    .i_resp_data  (i_resp_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_req_we     (d_req_we),
    .d_req_wdata  (d_req_wdata),
    .d_req_wstrb  (d_req_wstrb),
    .d_resp_valid (d_resp_valid),
    .d_resp_ready (d_resp_ready),
    .d_resp_data  (d_resp_data),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_addr   (m_req_addr),
    .m_req_we     (m_req_we),
    .m_req_wdata  (m_req_wdata),
    .m_req_wstrb  (m_req_wstrb),
    .m_resp_valid (m_resp_valid),
    .m_resp_ready (m_resp_ready),
    .m_resp_data  (m_resp_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock edge. Inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_req_valid = 0; i_req_addr = '0; i_resp_ready = 0;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
    d_resp_ready = 0; m_req_ready = 0; m_resp_valid = 0; m_resp_data = '0;
    repeat (3) step();
    checks++;
    if ({i_req_ready, d_req_ready, m_req_valid, m_resp_ready, busy, i_resp_valid, d_resp_valid} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {i_req_ready, d_req_ready, m_req_valid, m_resp_ready, busy, i_resp_valid, d_resp_valid});
    end
    checks++;
    if ({m_req_addr, m_req_we, m_req_wdata, m_req_wstrb} !== '0) begin
      failures++;
      $display("FAIL reset_fields: addr=%h we=%b wdata=%h wstrb=%h want all 0",
               m_req_addr, m_req_we, m_req_wdata, m_req_wstrb);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    i_req_valid = 1; i_req_addr = 32'h100; m_req_ready = 1; i_resp_ready = 1;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      failures++; $display("FAIL fetch_grant: got %b want 10", {i_req_ready, d_req_ready});
    end
    step();  // fire at edge N
    i_req_valid = 0;
    checks++;
    if ({m_req_valid, m_req_addr, m_req_we, m_req_wstrb, busy} !== {1'b1, 32'h100, 1'b0, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL fetch_req: valid=%b addr=%h we=%b wstrb=%h busy=%b want 1 00000100 0 0 1",
               m_req_valid, m_req_addr, m_req_we, m_req_wstrb, busy);
    end
    m_resp_valid = 1; m_resp_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (m_resp_ready !== 1'b0) begin
      failures++; $display("FAIL fetch_no_early_accept: m_resp_ready=%b want 0", m_resp_ready);
    end
    step();  // N+1: enter RESP
    m_req_ready = 0;
    checks++;
    if ({i_resp_valid, i_resp_data, d_resp_valid, m_resp_ready} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL fetch_resp: i_valid=%b data=%h d_valid=%b m_ready=%b want 1 deadbeef 0 1",
               i_resp_valid, i_resp_data, d_resp_valid, m_resp_ready);
    end
    step();  // N+2: response fires
    m_resp_valid = 0;
    checks++;
    if ({busy, m_req_valid, i_resp_valid} !== 3'b000) begin
      failures++; $display("FAIL fetch_idle_n3: busy/mreq/iresp=%b want 000", {busy, m_req_valid, i_resp_valid});
    end
  endtask

  task automatic test_write_stall();
    i_req_valid = 1; i_req_addr = 32'h200;
    d_req_valid = 1; d_req_addr = 32'h20; d_req_we = 1; d_req_wdata = 32'h12345678; d_req_wstrb = 4'hF;
    m_req_ready = 0;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b01) begin
      failures++; $display("FAIL write_grant: got %b want 01", {i_req_ready, d_req_ready});
    end
    step();
    d_req_valid = 0; d_req_addr = 32'hFFFF; d_req_wdata = '0; d_req_wstrb = '0; d_req_we = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb, i_req_ready, m_resp_ready}
          !== {1'b1, 32'h20, 1'b1, 32'h12345678, 4'hF, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL write_stall_%0d: v=%b a=%h we=%b wd=%h ws=%h irdy=%b mrr=%b want 1 20 1 12345678 f 0 0",
                 k, m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb, i_req_ready, m_resp_ready);
      end
      step();
    end
    m_req_ready = 1;
    step();  // enter RESP
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'h0; d_resp_ready = 1;
    #1;
    checks++;
    if ({d_resp_valid, i_resp_valid, m_resp_ready, i_req_ready} !== 4'b1010) begin
      failures++;
      $display("FAIL write_ack: d/i/mrr/irdy=%b want 1010", {d_resp_valid, i_resp_valid, m_resp_ready, i_req_ready});
    end
    i_req_valid = 0;
    step();
    m_resp_valid = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL write_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_d;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = 6'b101010;  // bit t = 1 means D wins transaction t: I,D,I,D,I,D
`else
    exp_d = 6'b111111;
`endif
    i_req_valid = 1; i_req_addr = 32'h400;
    d_req_valid = 1; d_req_addr = 32'h800; d_req_we = 0;
    m_req_ready = 1; m_resp_valid = 1; m_resp_data = 32'hCAFE0000;
    i_resp_ready = 1; d_resp_ready = 1;
    for (int t = 0; t < 6; t++) begin
      #1;
      checks++;
      if ({d_req_ready, i_req_ready} !== {exp_d[t], ~exp_d[t]}) begin
        failures++;
        $display("FAIL b2b_grant_%0d: d/i ready=%b%b want %b%b", t, d_req_ready, i_req_ready, exp_d[t], ~exp_d[t]);
      end
      step();  // REQ
      checks++;
      if (m_req_addr !== (exp_d[t] ? 32'h800 : 32'h400)) begin
        failures++; $display("FAIL b2b_addr_%0d: got %h want %h", t, m_req_addr, exp_d[t] ? 32'h800 : 32'h400);
      end
      step();  // RESP
      checks++;
      if ({d_resp_valid, i_resp_valid} !== {exp_d[t], ~exp_d[t]}) begin
        failures++;
        $display("FAIL b2b_resp_%0d: d/i valid=%b%b want %b%b", t, d_resp_valid, i_resp_valid, exp_d[t], ~exp_d[t]);
      end
      if (t == 5) begin
        i_req_valid = 0; d_req_valid = 0;
      end
      step();
    end
    m_resp_valid = 0; m_req_ready = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_resp_early();
    int pulses = 0;
    i_req_valid = 1; i_req_addr = 32'h140; i_resp_ready = 1;
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'hA5A5A5A5;
    step();  // captured, REQ
    i_req_valid = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({m_resp_ready, i_resp_valid} !== 2'b00) begin
        failures++; $display("FAIL early_hold_%0d: mrr/ivalid=%b want 00", k, {m_resp_ready, i_resp_valid});
      end
      if (k == 0) step();
    end
    m_req_ready = 1;
    #1;
    checks++;
    if (m_resp_ready !== 1'b0) begin
      failures++; $display("FAIL early_fire_cycle: m_resp_ready=%b want 0", m_resp_ready);
    end
    step();  // RESP
    m_req_ready = 0;
    if (i_resp_valid === 1'b1) pulses++;
    checks++;
    if ({m_resp_ready, i_resp_data} !== {1'b1, 32'hA5A5A5A5}) begin
      failures++; $display("FAIL early_resp: mrr=%b data=%h want 1 a5a5a5a5", m_resp_ready, i_resp_data);
    end
    step();  // IDLE, memory still presenting valid
    if (i_resp_valid === 1'b1) pulses++;
    step();
    if (i_resp_valid === 1'b1) pulses++;
    m_resp_valid = 0;
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL early_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_resp_backpressure();
    d_req_valid = 1; d_req_addr = 32'h44; d_req_we = 0; d_req_wstrb = 4'h0;
    m_req_ready = 1; d_resp_ready = 0;
    step();  // REQ
    d_req_valid = 0;
    step();  // RESP
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'h55AA55AA;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({m_resp_ready, busy, d_resp_valid} !== 3'b011) begin
        failures++; $display("FAIL bp_hold_%0d: mrr/busy/dvalid=%b want 011", k, {m_resp_ready, busy, d_resp_valid});
      end
      step();
    end
    d_resp_ready = 1;
    #1;
    checks++;
    if ({m_resp_ready, d_resp_data} !== {1'b1, 32'h55AA55AA}) begin
      failures++; $display("FAIL bp_release: mrr=%b data=%h want 1 55aa55aa", m_resp_ready, d_resp_data);
    end
    step();
    m_resp_valid = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL bp_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    i_req_valid = 1; i_req_addr = 32'h180; m_req_ready = 1; i_resp_ready = 1;
    step();
    i_req_valid = 0;
    step();  // RESP
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'h11112222;
    #1;
    checks++;
    if ({busy, i_resp_valid} !== 2'b11) begin
      failures++; $display("FAIL rst_pre: busy/ivalid=%b want 11", {busy, i_resp_valid});
    end
    reset_n = 0;
    #1;
    checks++;
    if ({busy, m_req_valid, m_resp_ready, i_resp_valid, d_resp_valid, i_req_ready, d_req_ready, m_req_addr} !== '0) begin
      failures++;
      $display("FAIL rst_mid: busy=%b mv=%b mrr=%b iv=%b dv=%b addr=%h want all 0",
               busy, m_req_valid, m_resp_ready, i_resp_valid, d_resp_valid, m_req_addr);
    end
    m_resp_valid = 0;
    step();
    reset_n = 1;
    step();
    i_req_valid = 1; i_req_addr = 32'h300; m_req_ready = 1;
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_after_grant: i_req_ready=%b want 1", i_req_ready);
    end
    step();
    i_req_valid = 0;
    checks++;
    if ({m_req_valid, m_req_addr} !== {1'b1, 32'h300}) begin
      failures++; $display("FAIL rst_after_req: v=%b addr=%h want 1 00000300", m_req_valid, m_req_addr);
    end
    step();
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'h0BADF00D;
    #1;
    checks++;
    if ({i_resp_valid, i_resp_data} !== {1'b1, 32'h0BADF00D}) begin
      failures++; $display("FAIL rst_after_resp: v=%b data=%h want 1 0badf00d", i_resp_valid, i_resp_data);
    end
    step();
    m_resp_valid = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_after_idle: busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_stall();
    test_back_to_back();
    test_resp_early();
    test_resp_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Shares a single memory request/response port between the instruction-fetch requester and the load/store requester. Sits between the fetch stage / load-store unit and the memory. Allows exactly one transaction in flight: captures the winning request, presents it to memory, and routes the response back to its owner. Arbitration is fixed-priority or round-robin, selected at compile time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req_valid / i_req_ready  in / out  1  fetch request handshake
- i_req_addr  in  ADDR_W  fetch address
- i_resp_valid / i_resp_ready  out / in  1  fetch response handshake
- i_resp_data  out  DATA_W  fetch read data
- d_req_valid / d_req_ready  in / out  1  data request handshake
- d_req_addr  in  ADDR_W  data address
- d_req_we  in  1  1 = write, 0 = read
- d_req_wdata  in  DATA_W  write data
- d_req_wstrb  in  DATA_W/8  byte enables
- d_resp_valid / d_resp_ready  out / in  1  data response handshake (read data, or write ack)
- d_resp_data  out  DATA_W  data read data
- m_req_valid / m_req_ready  out / in  1  memory request handshake
- m_req_addr, m_req_we, m_req_wdata, m_req_wstrb  out  ADDR_W, 1, DATA_W, DATA_W/8  memory request fields
- m_resp_valid / m_resp_ready  in / out  1  memory response handshake
- m_resp_data  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - REQ: request held to memory.
  - RESP: awaiting memory response.
- IDLE:
  - If any requester is valid, assert x_req_ready for the winner only, combinationally, in the same cycle.
  - On that fire, capture addr/we/wdata/wstrb and owner into registers, then go to REQ.
  - Fetch requests are captured with we=0 and wstrb=0.
- Arbitration when both requesters are valid:
  - With the macro: round-robin via last_grant.
  - Without it: data wins.
  - A single valid requester always wins.
- REQ:
  - m_req_valid=1, driving the registered fields, which stay stable until m_req_ready.
  - On m_req_valid & m_req_ready, go to RESP.
- RESP:
  - m_resp_ready = owner's resp_ready.
  - Owner's resp_valid = m_resp_valid; resp_data = m_resp_data (combinational pass-through).
  - On the response fire, go to IDLE.
- The non-owner's resp_valid is always 0.
- Both x_req_ready are 0 outside IDLE; requesters that are valid meanwhile wait.
- m_resp_ready is 0 outside RESP. A response arriving in the m_req fire cycle or earlier is not accepted; memory holds it.
- Writes complete only on a memory response (ack); d_resp_data is don't-care for writes.

## Timing
- Reset (asynchronous assert; leaves IDLE on first clk edge after deassert):
  - State goes to IDLE; all valid/ready outputs and busy are 0.
  - Captured fields are 0; last_grant = DATA, so the first tie goes to fetch.
- Latency with zero-wait memory: requester fire at cycle N; m_req_valid at N+1; earliest response fire at N+2; back to IDLE at N+3.
- Peak throughput: one transaction per 3 cycles. No grant is made in the cycle the response fires.
- last_grant updates only on a requester fire in IDLE.
- Reset mid-transaction drops the transaction silently. The response is never delivered; memory must also be reset.
- Back-pressure:
  - m_req_ready=0 holds REQ indefinitely with fields stable.
  - Owner resp_ready=0 holds RESP.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, grant the requester not equal to last_grant.
  - A continuously-valid requester is served at least every other transaction.
- Undefined:
  - Fixed priority, data over fetch; the last_grant register is not built.
  - A continuously-valid data requester may starve fetch.

## Structure
- Package imem_dmem_arb_pkg:
  - arb_state_e {IDLE, REQ, RESP}
  - owner_e {OWN_I, OWN_D}
- Sub-module arb_pick2 contains the tie-break logic, including last_grant under the macro:
  - Inputs: two valid bits plus the fire/update strobe.
  - Output: one-hot grant.
- The top module holds the FSM, the capture registers and the response mux.

## Test plan
- Single fetch, addr 0x100, memory m_req_ready=1, response data 0xDEADBEEF one cycle after fire:
  - m_req_addr = 0x100 with we=0.
  - i_resp_data = 0xDEADBEEF.
  - d_resp_valid stays 0.
  - Back in IDLE 3 cycles after the request fire.
- Data write to 0x20, wdata 0x12345678, wstrb 0xF, memory stalls m_req_ready low for 4 cycles:
  - m_req fields stable all 4 cycles.
  - d_resp_valid on the ack.
  - i_req_ready stays 0 throughout.
- Both requesters continuously valid for 6 transactions:
  - With ARB_ROUND_ROBIN_EN: grant order I, D, I, D, I, D.
  - Without it: all D.
- Memory response held valid during REQ:
  - Not accepted until RESP.
  - Owner sees exactly one resp_valid pulse.
- Owner resp_ready low for 3 cycles during RESP:
  - m_resp_ready stays low and busy stays 1.
  - Completes on the first cycle resp_ready is high.
- reset_n pulsed low while in RESP:
  - All outputs 0 immediately.
  - IDLE after release; the next fetch completes normally.
